// File: rtl/hit_if.sv
// Pixel-side signals of the hit detector: collision flags in, hit/cooldown status out.
// Latency: none (signal bundle only).
// Backpressure: none; all signals are level or single-cycle pulse, no handshake.
interface hit_if;
  logic game_on;
  logic vblnk_in;
  logic player_px;
  logic obstacle_px;
  logic btn_hit;
  logic player_hit;
  logic invincible;
  logic blink;

  // Drawing pipeline side: drives video/pixel flags, consumes hit status.
  modport master (
    output game_on, vblnk_in, player_px, obstacle_px, btn_hit,
    input  player_hit, invincible, blink
  );

  // Detector side.
  modport slave (
    input  game_on, vblnk_in, player_px, obstacle_px, btn_hit,
    output player_hit, invincible, blink
  );
endinterface

// File: rtl/hit_detector.sv
// Per-frame player/obstacle collision detector with post-hit invulnerability and blink flag.
// Latency: player_hit is registered, high the cycle after the edge that sampled the frame end.
// Backpressure: none; HP control must accept the one-cycle pulse. Macro HIT_BUTTON_EN adds a debounced test button.
module hit_detector #(
  parameter int INVUL_FRAMES    = 60,
  parameter int BLINK_FRAMES    = 4,
  parameter int DEBOUNCE_CYCLES = 650000
) (
  input  logic clk,
  input  logic rst,
  hit_if.slave hb
);

  typedef enum logic [1:0] {IDLE, ARMED, COOLDOWN} state_t;

  localparam logic [7:0] INVUL_LOAD = 8'(INVUL_FRAMES);
  localparam logic [7:0] BLINK_LOAD = 8'(BLINK_FRAMES);

  state_t     state_q, state_d;
  logic       vblnk_q;
  logic       coll_q, coll_d;
  logic [7:0] frames_q, frames_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       blink_q, blink_d;
  logic       hit_q, hit_d;
  logic       frame_end;
  logic       btn_evt;
  logic       overlap;

  // Rising edge of vertical blank marks the end of the frame.
  assign frame_end = hb.vblnk_in & ~vblnk_q;
  // Overlaps seen during blank (including the frame-end cycle) do not count.
  assign overlap   = ~hb.vblnk_in & hb.player_px & hb.obstacle_px;

`ifdef HIT_BUTTON_EN
  localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic        btn_s1_q, btn_s2_q;
  logic        btn_lvl_q;
  logic [19:0] db_cnt_q;

  // Synchronize the raw button, then accept a new level only after it has been stable long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1_q  <= 1'b0;
      btn_s2_q  <= 1'b0;
      btn_lvl_q <= 1'b0;
      db_cnt_q  <= 20'd0;
    end else begin
      btn_s1_q <= hb.btn_hit;
      btn_s2_q <= btn_s1_q;
      if (btn_s2_q != btn_lvl_q) begin
        if (db_cnt_q == DB_LAST) begin
          btn_lvl_q <= btn_s2_q;
          db_cnt_q  <= 20'd0;
        end else begin
          db_cnt_q <= db_cnt_q + 20'd1;
        end
      end else begin
        db_cnt_q <= 20'd0;
      end
    end
  end

  // One event per accepted press: the cycle the debounced level goes 0 -> 1.
  assign btn_evt = btn_s2_q & ~btn_lvl_q & (db_cnt_q == DB_LAST);
`else
  logic unused_btn;
  assign unused_btn = hb.btn_hit;
  assign btn_evt    = 1'b0;
`endif

  // State, counters, flags and the registered hit pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vblnk_q     <= 1'b0;
      coll_q      <= 1'b0;
      frames_q    <= 8'd0;
      blink_cnt_q <= 8'd0;
      blink_q     <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      vblnk_q     <= hb.vblnk_in;
      coll_q      <= coll_d;
      frames_q    <= frames_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      hit_q       <= hit_d;
    end
  end

  // Next-state logic: arm, latch a collision, fire once at frame end, then count down the cooldown.
  always_comb begin
    state_d     = state_q;
    coll_d      = coll_q;
    frames_d    = frames_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    hit_d       = 1'b0;

    case (state_q)
      IDLE: begin
        coll_d      = 1'b0;
        frames_d    = 8'd0;
        blink_cnt_d = 8'd0;
        blink_d     = 1'b0;
        if (hb.game_on) state_d = ARMED;
      end

      ARMED: begin
        if (frame_end && coll_q) begin
          hit_d       = 1'b1;
          coll_d      = 1'b0;
          frames_d    = INVUL_LOAD;
          blink_cnt_d = BLINK_LOAD;
          blink_d     = 1'b1;
          state_d     = COOLDOWN;
        end else if (overlap || btn_evt) begin
          coll_d = 1'b1;
        end
      end

      COOLDOWN: begin
        coll_d = 1'b0;
        if (frame_end) begin
          frames_d    = frames_q - 8'd1;
          blink_cnt_d = blink_cnt_q - 8'd1;
          if (blink_cnt_q == 8'd1) begin
            blink_d     = ~blink_q;
            blink_cnt_d = BLINK_LOAD;
          end
          if (frames_q == 8'd1) begin
            blink_d = 1'b0;
            state_d = ARMED;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Leaving the game discards everything, including a hit due this cycle.
    if (!hb.game_on) begin
      state_d     = IDLE;
      coll_d      = 1'b0;
      frames_d    = 8'd0;
      blink_cnt_d = 8'd0;
      blink_d     = 1'b0;
      hit_d       = 1'b0;
    end
  end

  assign hb.player_hit = hit_q;
  assign hb.invincible = (state_q == COOLDOWN);
  assign hb.blink      = blink_q;

endmodule

// File: tb/tb_hit_detector.sv
module tb_hit_detector;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hit_if hb();

  hit_detector #(
    .INVUL_FRAMES   (3),
    .BLINK_FRAMES   (1),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hb (hb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  // One frame: active region with optional overlap/button windows, then 4 blank cycles.
  // Reports outputs in the cycle after the frame end and any hit pulses seen elsewhere.
  task automatic do_frame(input int n_act, input int ovl_lo, input int ovl_hi,
                          input int btn_lo, input int btn_hi, input bit blank_ovl,
                          output logic hit_fe, output logic inv_fe, output logic blink_fe,
                          output int other_hits);
    other_hits = 0;
    hb.vblnk_in = 1'b0;
    for (int c = 0; c < n_act; c++) begin
      hb.player_px   = (c >= ovl_lo) && (c <= ovl_hi);
      hb.obstacle_px = (c >= ovl_lo) && (c <= ovl_hi);
      hb.btn_hit     = (c >= btn_lo) && (c <= btn_hi);
      step();
      if (hb.player_hit) other_hits++;
    end
    hb.btn_hit     = 1'b0;
    hb.player_px   = blank_ovl;
    hb.obstacle_px = blank_ovl;
    hb.vblnk_in    = 1'b1;
    step();
    hit_fe   = hb.player_hit;
    inv_fe   = hb.invincible;
    blink_fe = hb.blink;
    for (int c = 0; c < 4; c++) begin
      step();
      if (hb.player_hit) other_hits++;
    end
    hb.player_px   = 1'b0;
    hb.obstacle_px = 1'b0;
  endtask

  logic h, inv, bl;
  int   oth;
  bit   exp_hit   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  bit   exp_inv   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  bit   exp_blink [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    checks = 0;
    errors = 0;
    rst            = 1'b1;
    hb.game_on     = 1'b1;
    hb.vblnk_in    = 1'b0;
    hb.player_px   = 1'b0;
    hb.obstacle_px = 1'b0;
    hb.btn_hit     = 1'b0;

    // Reset held 3 cycles with game_on high.
    step(); step(); step();
    chk("rst_hit", hb.player_hit, 0);
    chk("rst_inv", hb.invincible, 0);
    chk("rst_blink", hb.blink, 0);
    rst = 1'b0;
    step();
    chk("post_rst_hit", hb.player_hit, 0);
    chk("post_rst_inv", hb.invincible, 0);

    // Frame 0: single overlap pixel mid-frame.
    hb.vblnk_in = 1'b0;
    for (int c = 0; c < 10; c++) begin
      hb.player_px   = (c == 5);
      hb.obstacle_px = (c == 5);
      step();
      chk("f0_no_early_hit", hb.player_hit, 0);
    end
    hb.player_px   = 1'b0;
    hb.obstacle_px = 1'b0;
    hb.vblnk_in    = 1'b1;
    step();
    chk("f0_hit", hb.player_hit, 1);
    chk("f0_inv", hb.invincible, 1);
    chk("f0_blink", hb.blink, 1);
    step();
    chk("f0_hit_one_cycle", hb.player_hit, 0);
    chk("f0_inv_held", hb.invincible, 1);
    step(); step(); step();

    // Frames 1..4: overlap every frame; cooldown of 3 frames, blink every frame.
    for (int f = 0; f < 4; f++) begin
      do_frame(10, 3, 4, -1, -1, 1'b0, h, inv, bl, oth);
      chk($sformatf("f%0d_hit", f + 1), h, exp_hit[f]);
      chk($sformatf("f%0d_inv", f + 1), inv, exp_inv[f]);
      chk($sformatf("f%0d_blink", f + 1), bl, exp_blink[f]);
      chk($sformatf("f%0d_other", f + 1), oth, 0);
    end

    // Frames 5..7: no overlap, cooldown runs out after the third frame end.
    do_frame(10, -1, -1, -1, -1, 1'b0, h, inv, bl, oth);
    chk("f5_blink", bl, 0);
    do_frame(10, -1, -1, -1, -1, 1'b0, h, inv, bl, oth);
    chk("f6_blink", bl, 1);
    chk("f6_inv", inv, 1);
    do_frame(10, -1, -1, -1, -1, 1'b0, h, inv, bl, oth);
    chk("f7_hit", h, 0);
    chk("f7_inv", inv, 0);
    chk("f7_blink", bl, 0);

    // 200 overlapping pixels in one frame: one pulse only.
    do_frame(210, 5, 204, -1, -1, 1'b0, h, inv, bl, oth);
    chk("multi_hit", h, 1);
    chk("multi_other", oth, 0);
    for (int f = 0; f < 3; f++) begin
      do_frame(10, 2, 6, -1, -1, 1'b0, h, inv, bl, oth);
      chk("multi_cool_hit", h, 0);
      chk("multi_cool_other", oth, 0);
    end
    chk("multi_cool_done", inv, 0);

    // game_on drop during cooldown clears invincible and blink.
    do_frame(10, 3, 3, -1, -1, 1'b0, h, inv, bl, oth);
    chk("goff_setup_hit", h, 1);
    hb.game_on = 1'b0;
    step();
    chk("goff_cool_inv", hb.invincible, 0);
    chk("goff_cool_blink", hb.blink, 0);
    hb.game_on = 1'b1;
    step();

    // game_on dropped mid-frame after an overlap: pending collision discarded.
    hb.vblnk_in = 1'b0;
    for (int c = 0; c < 20; c++) begin
      hb.player_px   = (c == 3);
      hb.obstacle_px = (c == 3);
      hb.game_on     = (c < 10);
      step();
    end
    hb.player_px   = 1'b0;
    hb.obstacle_px = 1'b0;
    hb.vblnk_in    = 1'b1;
    step();
    chk("goff_mid_hit", hb.player_hit, 0);
    chk("goff_mid_inv", hb.invincible, 0);
    chk("goff_mid_blink", hb.blink, 0);
    step(); step();
    hb.game_on = 1'b1;
    do_frame(10, -1, -1, -1, -1, 1'b0, h, inv, bl, oth);
    chk("reen_hit", h, 0);
    chk("reen_other", oth, 0);

    // game_on falls in the very cycle the frame end would fire a hit.
    hb.vblnk_in = 1'b0;
    for (int c = 0; c < 10; c++) begin
      hb.player_px   = (c == 4);
      hb.obstacle_px = (c == 4);
      step();
    end
    hb.player_px   = 1'b0;
    hb.obstacle_px = 1'b0;
    hb.vblnk_in    = 1'b1;
    hb.game_on     = 1'b0;
    step();
    chk("goff_fe_hit", hb.player_hit, 0);
    hb.game_on = 1'b1;
    step();
    chk("goff_fe_hit_late", hb.player_hit, 0);
    step(); step();

    // Overlap only during blank (including the frame-end cycle) is not counted.
    do_frame(10, -1, -1, -1, -1, 1'b1, h, inv, bl, oth);
    chk("blank_ovl_fe", h, 0);
    do_frame(10, -1, -1, -1, -1, 1'b0, h, inv, bl, oth);
    chk("blank_ovl_next", h, 0);
    chk("blank_ovl_other", oth, 0);

`ifdef HIT_BUTTON_EN
    // 5-cycle glitch is shorter than the debounce window.
    do_frame(40, -1, -1, 5, 9, 1'b0, h, inv, bl, oth);
    chk("btn_glitch_hit", h, 0);
    chk("btn_glitch_other", oth, 0);
    // 20-cycle press in ARMED.
    do_frame(40, -1, -1, 5, 24, 1'b0, h, inv, bl, oth);
    chk("btn_press_hit", h, 1);
    chk("btn_press_other", oth, 0);
    // Press during cooldown is discarded.
    do_frame(40, -1, -1, 5, 24, 1'b0, h, inv, bl, oth);
    chk("btn_cool_hit", h, 0);
    do_frame(40, -1, -1, -1, -1, 1'b0, h, inv, bl, oth);
    do_frame(40, -1, -1, -1, -1, 1'b0, h, inv, bl, oth);
    chk("btn_cool_done", inv, 0);
    do_frame(40, -1, -1, -1, -1, 1'b0, h, inv, bl, oth);
    chk("btn_cool_after", h, 0);
    chk("btn_cool_other", oth, 0);
`else
    // Without the button feature a long press does nothing.
    do_frame(40, -1, -1, 5, 24, 1'b0, h, inv, bl, oth);
    chk("btn_ignored_hit", h, 0);
    chk("btn_ignored_other", oth, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
